// File: rtl/bcd_race_countdown.sv
// rtl/bcd_race_countdown.sv - multi-lane BCD race countdown with winner latch
// Optional PENALTY_EN: wrong[i] increments lane i, saturating at START_VALUE.
module bcd_race_countdown #(
  parameter int NUM_PLAYERS = 2,
  parameter int DIGITS      = 2,
  parameter int START_VALUE = 32,
  localparam int WW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int LW = DIGITS * 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          restart,
  input  logic [NUM_PLAYERS-1:0]        correct,
  input  logic [NUM_PLAYERS-1:0]        wrong,
  output logic [NUM_PLAYERS*LW-1:0]     digits,
  output logic [NUM_PLAYERS-1:0]        ended,
  output logic                          game_over,
  output logic [WW-1:0]                 winner
);

  typedef enum logic {RUN, OVER} state_t;

  function automatic logic [LW-1:0] to_bcd(input int value);
    logic [LW-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int k = 0; k < DIGITS; k++) begin
      r[k*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [LW-1:0] bcd_dec(input logic [LW-1:0] x);
    logic [LW-1:0] r;
    logic borrow;
    r = x;
    borrow = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (borrow) begin
        if (x[k*4 +: 4] == 4'd0) begin
          r[k*4 +: 4] = 4'd9;
        end else begin
          r[k*4 +: 4] = x[k*4 +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

`ifdef PENALTY_EN
  function automatic logic [LW-1:0] bcd_inc(input logic [LW-1:0] x);
    logic [LW-1:0] r;
    logic carry;
    r = x;
    carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (x[k*4 +: 4] == 4'd9) begin
          r[k*4 +: 4] = 4'd0;
        end else begin
          r[k*4 +: 4] = x[k*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction
`else
  logic unused_wrong;
  assign unused_wrong = ^wrong;
`endif

  localparam logic [LW-1:0] START_BCD = to_bcd(START_VALUE);

  state_t                              state_q, state_d;
  logic [NUM_PLAYERS-1:0][LW-1:0]      lanes_q, lanes_d;
  logic [NUM_PLAYERS-1:0]              ended_q, ended_d;
  logic [WW-1:0]                       winner_q, winner_d;
  logic [NUM_PLAYERS-1:0]              fin;

  always_comb begin
    state_d  = state_q;
    lanes_d  = lanes_q;
    ended_d  = ended_q;
    winner_d = winner_q;
    fin      = '0;
    if (state_q == RUN) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (correct[i] && (lanes_q[i] != '0)) begin
          lanes_d[i] = bcd_dec(lanes_q[i]);
          fin[i]     = (lanes_d[i] == '0);
        end
`ifdef PENALTY_EN
        else if (wrong[i] && !correct[i] && (lanes_q[i] != START_BCD)) begin
          lanes_d[i] = bcd_inc(lanes_q[i]);
        end
`endif
      end
      // Descending scan so the lowest finishing lane wins a tie.
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
        if (fin[i]) winner_d = WW'(i);
      end
      if (|fin) begin
        ended_d = ended_q | fin;
        state_d = OVER;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || restart) begin
      state_q  <= RUN;
      lanes_q  <= {NUM_PLAYERS{START_BCD}};
      ended_q  <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      lanes_q  <= lanes_d;
      ended_q  <= ended_d;
      winner_q <= winner_d;
    end
  end

  assign digits    = lanes_q;
  assign ended     = ended_q;
  assign game_over = (state_q == OVER);
  assign winner    = winner_q;

endmodule

// File: tb/tb_bcd_race_countdown.sv
// tb/tb_bcd_race_countdown.sv - directed vector bench for bcd_race_countdown
// Honours PENALTY_EN when defined for the build.
module tb_bcd_race_countdown;

  logic        clk = 1'b0;
  logic        resetn;
  logic        restart;
  logic [1:0]  correct, wrong, correct2;
  logic [15:0] digits;
  logic [1:0]  ended, ended2;
  logic        game_over, game_over2;
  logic [0:0]  winner, winner2;
  logic [23:0] digits2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_race_countdown dut (
    .clk(clk), .resetn(resetn), .restart(restart), .correct(correct), .wrong(wrong),
    .digits(digits), .ended(ended), .game_over(game_over), .winner(winner)
  );

  bcd_race_countdown #(.NUM_PLAYERS(2), .DIGITS(3), .START_VALUE(100)) dut3 (
    .clk(clk), .resetn(resetn), .restart(restart), .correct(correct2), .wrong(2'b00),
    .digits(digits2), .ended(ended2), .game_over(game_over2), .winner(winner2)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  cor;
    logic [1:0]  wr;
    logic [15:0] dg;
    logic [1:0]  en;
    logic        go;
    logic [0:0]  win;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [15:0] dg, input logic [1:0] en,
                           input logic go, input logic [0:0] win);
    check({name, ".digits"}, 32'(digits), 32'(dg));
    check({name, ".ended"}, 32'(ended), 32'(en));
    check({name, ".game_over"}, 32'(game_over), 32'(go));
    check({name, ".winner"}, 32'(winner), 32'(win));
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'b01, 2'b00, 16'h3231, 2'b00, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 2'b01, 2'b00, 16'h3230, 2'b00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 2'b01, 2'b00, 16'h3229, 2'b00, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 2'b11, 2'b00, 16'h3128, 2'b00, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 2'b00, 2'b00, 16'h3128, 2'b00, 1'b0, 1'b0};
`ifdef PENALTY_EN
    vecs[5] = '{1'b0, 2'b00, 2'b01, 16'h3129, 2'b00, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 2'b01, 2'b01, 16'h3128, 2'b00, 1'b0, 1'b0};
`else
    vecs[5] = '{1'b0, 2'b00, 2'b01, 16'h3128, 2'b00, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 2'b01, 2'b01, 16'h3127, 2'b00, 1'b0, 1'b0};
`endif
    vecs[7] = '{1'b1, 2'b00, 2'b00, 16'h3232, 2'b00, 1'b0, 1'b0};

    resetn = 1'b0; restart = 1'b0; correct = '0; wrong = '0; correct2 = '0;
    step();
    step();
    resetn = 1'b1;
    check_all("reset", 16'h3232, 2'b00, 1'b0, 1'b0);
    check("reset3.digits", 32'(digits2), 32'h100100);

    correct2 = 2'b01;
    step();
    correct2 = 2'b00;
    check("borrow3.digits", 32'(digits2), 32'h100099);
    check("borrow3.idle", 32'(digits), 32'h3232);

    for (int v = 0; v < 8; v++) begin
      restart = vecs[v].rst; correct = vecs[v].cor; wrong = vecs[v].wr;
      step();
      check_all($sformatf("vec%0d", v), vecs[v].dg, vecs[v].en, vecs[v].go, vecs[v].win);
    end
    restart = 1'b0; correct = '0; wrong = '0;

    // lane 1 held for 31 cycles, then one last pulse finishes it
    correct = 2'b10;
    repeat (31) step();
    check_all("lane1_at1", 16'h0132, 2'b00, 1'b0, 1'b0);
    step();
    correct = 2'b00;
    check_all("lane1_win", 16'h0032, 2'b10, 1'b1, 1'b1);
    correct = 2'b01; wrong = 2'b11;
    step();
    correct = 2'b00; wrong = 2'b00;
    check_all("frozen", 16'h0032, 2'b10, 1'b1, 1'b1);

    restart = 1'b1;
    step();
    restart = 1'b0;
    check_all("restart_over", 16'h3232, 2'b00, 1'b0, 1'b0);

    correct = 2'b11;
    repeat (31) step();
    check_all("tie_at1", 16'h0101, 2'b00, 1'b0, 1'b0);
    step();
    correct = 2'b00;
    check_all("tie", 16'h0000, 2'b11, 1'b1, 1'b0);

    resetn = 1'b0; restart = 1'b1; correct = 2'b11;
    step();
    resetn = 1'b1; restart = 1'b0; correct = 2'b00;
    check_all("reset_restart", 16'h3232, 2'b00, 1'b0, 1'b0);

`ifdef PENALTY_EN
    correct = 2'b01;
    step();
    correct = 2'b00;
    check("pen_pre", 32'(digits), 32'h3231);
    wrong = 2'b01;
    step();
    check("pen_inc", 32'(digits), 32'h3232);
    step();
    wrong = 2'b00;
    check("pen_sat", 32'(digits), 32'h3232);
    correct = 2'b01;
    repeat (13) step();
    correct = 2'b00;
    check("pen_19", 32'(digits), 32'h3219);
    wrong = 2'b01;
    step();
    wrong = 2'b00;
    check("pen_carry", 32'(digits), 32'h3220);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
